div_issue: RTL

DIV_ISSUE -- requirements
Module: div_issue

---
 rtl/div_pkg.sv | 19 +
 rtl/div_issue_fifo.sv | 55 +++++
 rtl/div_issue.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider issue stage: div_op bit positions, in-flight FSM encoding
// and default tag width.
package div_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned DIV_OP_W      = 3;
    localparam int unsigned DEFAULT_TAG_W = 6;

    localparam int unsigned DIV_OP_UNSIGNED = 0;
    localparam int unsigned DIV_OP_REM      = 1;
    localparam int unsigned DIV_OP_WORD     = 2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBusy   = 2'd1,
        StKilled = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_issue_fifo.sv
// Pending-op FIFO for the divider issue stage. Pointers carry one extra wrap bit so that
// full and empty can be told apart when the index bits match.
module div_issue_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_en, pop_en;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // Storage needs no reset: entries are only visible between valid pointers.
    always_ff @(posedge clk) begin
        if (push_en && !flush) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/div_issue.sv
// Divider issue stage: queues ops, feeds one at a time to the divider, and holds one result
// for writeback. Optional last-result bypass cache enabled by macro DIV_BYPASS_EN.
module div_issue
    import div_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter int unsigned TAG_W       = DEFAULT_TAG_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [XLEN-1:0]     issue_operand1,
    input  logic [XLEN-1:0]     issue_operand2,
    input  logic [DIV_OP_W-1:0] issue_div_op,
    input  logic [TAG_W-1:0]    issue_tag,
    input  logic                flush,
    output logic                div_req_valid,
    input  logic                div_req_ready,
    output logic [XLEN-1:0]     div_operand1,
    output logic [XLEN-1:0]     div_operand2,
    output logic [DIV_OP_W-1:0] div_op,
    input  logic                div_resp_valid,
    input  logic [XLEN-1:0]     div_resp_result,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [XLEN-1:0]     wb_result,
    output logic [TAG_W-1:0]    wb_tag
);

    localparam int unsigned ENTRY_W = 2 * XLEN + DIV_OP_W + TAG_W;

    logic [ENTRY_W-1:0]  fifo_wdata, fifo_rdata;
    logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [XLEN-1:0]     head_op1, head_op2;
    logic [DIV_OP_W-1:0] head_op;
    logic [TAG_W-1:0]    head_tag;

    div_state_e          state_q, state_d;
    logic [TAG_W-1:0]    tag_q;
    logic                wb_valid_q;
    logic [XLEN-1:0]     wb_result_q;
    logic [TAG_W-1:0]    wb_tag_q;

    logic                can_issue, req_fire, resp_accept;
    logic                cache_hit, bypass_pop, bypass_pend;
    logic [XLEN-1:0]     bypass_result;
    logic [TAG_W-1:0]    bypass_tag;

    assign fifo_wdata = {issue_operand1, issue_operand2, issue_div_op, issue_tag};
    assign {head_op1, head_op2, head_op, head_tag} = fifo_rdata;
    assign fifo_push  = issue_valid && issue_ready;
    assign fifo_pop   = req_fire || bypass_pop;

    div_issue_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (flush),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign div_operand1 = head_op1;
    assign div_operand2 = head_op2;
    assign div_op       = head_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A response arriving with a flush is dropped and the divider is free again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (req_fire) state_d = StBusy;
            StBusy: begin
                if (div_resp_valid) begin
                    state_d = StIdle;
                end else if (flush) begin
                    state_d = StKilled;
                end
            end
            StKilled: if (div_resp_valid) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Only one op may occupy in-flight + result slot, so issue waits for an empty slot.
    always_comb begin
        issue_ready   = !rst && !fifo_full && !flush;
        can_issue     = !fifo_empty && (state_q == StIdle) && !wb_valid_q && !flush &&
                        !bypass_pend;
        div_req_valid = can_issue && !cache_hit;
        bypass_pop    = can_issue && cache_hit;
        req_fire      = div_req_valid && div_req_ready;
        resp_accept   = div_resp_valid && (state_q == StBusy) && !flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= '0;
        end else if (req_fire) begin
            tag_q <= head_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q  <= 1'b0;
            wb_result_q <= '0;
            wb_tag_q    <= '0;
        end else if (flush) begin
            wb_valid_q  <= 1'b0;
        end else if (resp_accept) begin
            wb_valid_q  <= 1'b1;
            wb_result_q <= div_resp_result;
            wb_tag_q    <= tag_q;
        end else if (bypass_pend) begin
            wb_valid_q  <= 1'b1;
            wb_result_q <= bypass_result;
            wb_tag_q    <= bypass_tag;
        end else if (wb_valid_q && wb_ready) begin
            wb_valid_q  <= 1'b0;
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_result = wb_result_q;
    assign wb_tag    = wb_tag_q;

`ifdef DIV_BYPASS_EN
    logic [XLEN-1:0]     infl_op1_q, infl_op2_q;
    logic [DIV_OP_W-1:0] infl_op_q;
    logic                cache_valid_q;
    logic [DIV_OP_W-1:0] cache_op_q;
    logic [XLEN-1:0]     cache_op1_q, cache_op2_q, cache_result_q;
    logic                bypass_pend_q;
    logic [TAG_W-1:0]    bypass_tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl_op1_q <= '0;
            infl_op2_q <= '0;
            infl_op_q  <= '0;
        end else if (req_fire) begin
            infl_op1_q <= head_op1;
            infl_op2_q <= head_op2;
            infl_op_q  <= head_op;
        end
    end

    // Flush leaves the cache intact: a killed op does not invalidate an earlier result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid_q  <= 1'b0;
            cache_op_q     <= '0;
            cache_op1_q    <= '0;
            cache_op2_q    <= '0;
            cache_result_q <= '0;
        end else if (resp_accept) begin
            cache_valid_q  <= 1'b1;
            cache_op_q     <= infl_op_q;
            cache_op1_q    <= infl_op1_q;
            cache_op2_q    <= infl_op2_q;
            cache_result_q <= div_resp_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bypass_pend_q <= 1'b0;
            bypass_tag_q  <= '0;
        end else begin
            bypass_pend_q <= bypass_pop;
            if (bypass_pop) begin
                bypass_tag_q <= head_tag;
            end
        end
    end

    assign cache_hit     = cache_valid_q && (head_op == cache_op_q) &&
                           (head_op1 == cache_op1_q) && (head_op2 == cache_op2_q);
    assign bypass_pend   = bypass_pend_q;
    assign bypass_result = cache_result_q;
    assign bypass_tag    = bypass_tag_q;
`else
    assign cache_hit     = 1'b0;
    assign bypass_pend   = 1'b0;
    assign bypass_result = '0;
    assign bypass_tag    = '0;
`endif

endmodule
